// File: rtl/noc_pkg.sv
// Shared router-port types and constants: direction encoding, counter width, flit entry.
// No logic and therefore no latency.
// No flow control lives here.
package noc_pkg;

    localparam int DIR_W = 6;

    // Bit 5 set means no direction.
    localparam logic [DIR_W-1:0] DIR_NULL = 6'b100000;

    // One-hot output ports in bits 4:0. DIR_W already names the width,
    // so west uses the long name.
    localparam logic [DIR_W-1:0] DIR_N    = 6'b000001;
    localparam logic [DIR_W-1:0] DIR_E    = 6'b000010;
    localparam logic [DIR_W-1:0] DIR_S    = 6'b000100;
    localparam logic [DIR_W-1:0] DIR_WEST = 6'b001000;
    localparam logic [DIR_W-1:0] DIR_L    = 6'b010000;

    localparam int CNT_W       = 3;
    localparam int FLIT_W_DFLT = 32;

    // Buffered entry at the default flit width. The parameterised top
    // builds the same layout at its own FLIT_W.
    typedef struct packed {
        logic [FLIT_W_DFLT-1:0] flit;
        logic [DIR_W-1:0]       dir;
    } flit_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with occupancy count.
// Latency: a write is visible at the head one cycle later; there is no bypass.
// Backpressure: a push while full and a pop while empty are both ignored.
module sync_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     occ
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (occ == DEPTH_C);
    assign empty    = (occ == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    // Storage array: the contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy: DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/flit_track_buffer.sv
// Router input stage: buffers flits with their direction and tracks the packet position and header direction.
// Latency: a flit pushed into an empty buffer reaches the head one cycle later; every output is registered state.
// Backpressure: ready is !full and does not depend on grant, so a full buffer only drains.
module flit_track_buffer
    import noc_pkg::*;
#(
    parameter int FLIT_W  = 32,
    parameter int DEPTH   = 4,
    parameter int PKT_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] flit_i,
    input  logic [DIR_W-1:0]  dir_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [FLIT_W-1:0] flit_o,
    output logic [DIR_W-1:0]  dir_o,
    output logic [CNT_W-1:0]  count_o,
    output logic [DIR_W-1:0]  dir_record_o,
    input  logic [DIR_W-1:0]  dir_record_i,
    input  logic              grant_i,
    output logic              tail_o
);

    typedef struct packed {
        logic [FLIT_W-1:0] flit;
        logic [DIR_W-1:0]  dir;
    } entry_t;

    localparam int EW = $bits(entry_t);
    localparam int OW = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_LEN - 1);

    entry_t           wr_ent;
    entry_t           head_ent;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [OW-1:0]    occ;
    logic             unused_occ;
    logic [CNT_W-1:0] count;
    logic [DIR_W-1:0] dir_record;

    assign wr_ent.flit = flit_i;
    assign wr_ent.dir  = dir_i;
    assign push        = valid_i && !full;
    assign pop         = grant_i && !empty;
    assign unused_occ  = ^occ;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (wr_ent),
        .pop      (pop),
        .head_dat (head_ent),
        .full     (full),
        .empty    (empty),
        .occ      (occ)
    );

    // Packet position and recorded header direction both advance only when the head is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            dir_record <= DIR_NULL;
        end else if (pop) begin
            count <= (count == LAST_CNT) ? '0 : count + CNT_W'(1);
            if (count == '0) begin
                dir_record <= dir_record_i;
            end
        end
    end

    assign ready_o      = !full;
    assign flit_o       = empty ? '0 : head_ent.flit;
    assign dir_o        = empty ? DIR_NULL : head_ent.dir;
    assign count_o      = count;
    assign dir_record_o = dir_record;
    assign tail_o       = !empty && (count == LAST_CNT);

endmodule

// File: tb/tb_flit_track_buffer.sv
module tb_flit_track_buffer;

    localparam int FW    = 32;
    localparam int DEPTH = 4;
    localparam int PLEN  = 4;

    localparam logic [5:0] D_NULL = 6'b100000;
    localparam logic [5:0] D_N    = 6'b000001;
    localparam logic [5:0] D_E    = 6'b000010;
    localparam logic [5:0] D_S    = 6'b000100;
    localparam logic [5:0] D_WST  = 6'b001000;
    localparam logic [5:0] D_L    = 6'b010000;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] flit_i;
    logic [5:0]    dir_i;
    logic          valid_i;
    logic          ready_o;
    logic [FW-1:0] flit_o;
    logic [5:0]    dir_o;
    logic [2:0]    count_o;
    logic [5:0]    dir_record_o;
    logic [5:0]    dir_record_i;
    logic          grant_i;
    logic          tail_o;

    // The direction logic returns the head's direction as the next record value.
    assign dir_record_i = dir_o;

    flit_track_buffer #(
        .FLIT_W  (FW),
        .DEPTH   (DEPTH),
        .PKT_LEN (PLEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flit_i       (flit_i),
        .dir_i        (dir_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .flit_o       (flit_o),
        .dir_o        (dir_o),
        .count_o      (count_o),
        .dir_record_o (dir_record_o),
        .dir_record_i (dir_record_i),
        .grant_i      (grant_i),
        .tail_o       (tail_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] f;
        logic [5:0]    d;
    } ent_t;

    ent_t       sb[$];
    logic [2:0] m_cnt;
    logic [5:0] m_rec;
    int         n_chk  = 0;
    int         n_pass = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs with the model; sampled 1 time unit after the rising edge.
    task automatic check_state(input string tag);
        chk({tag, ".ready"}, 64'(ready_o), 64'(sb.size() < DEPTH));
        if (sb.size() == 0) begin
            chk({tag, ".flit"}, 64'(flit_o), 64'(0));
            chk({tag, ".dir"},  64'(dir_o),  64'(D_NULL));
        end else begin
            chk({tag, ".flit"}, 64'(flit_o), 64'(sb[0].f));
            chk({tag, ".dir"},  64'(dir_o),  64'(sb[0].d));
        end
        chk({tag, ".count"}, 64'(count_o),      64'(m_cnt));
        chk({tag, ".rec"},   64'(dir_record_o), 64'(m_rec));
        chk({tag, ".tail"},  64'(tail_o),       64'(sb.size() > 0 && m_cnt == 3'(PLEN - 1)));
    endtask

    // One clock: check current outputs, drive inputs, clock, then update the model.
    task automatic cyc(input string tag, input logic v, input logic [FW-1:0] f,
                       input logic [5:0] d, input logic g);
        logic acc_push;
        logic acc_pop;
        ent_t e;
        check_state(tag);
        valid_i  = v;
        flit_i   = f;
        dir_i    = d;
        grant_i  = g;
        acc_push = v && (sb.size() < DEPTH);
        acc_pop  = g && (sb.size() > 0);
        @(posedge clk);
        #1;
        if (acc_pop) begin
            e = sb.pop_front();
            if (m_cnt == 3'd0) m_rec = e.d;
            m_cnt = (m_cnt == 3'(PLEN - 1)) ? 3'd0 : m_cnt + 3'd1;
        end
        if (acc_push) begin
            e.f = f;
            e.d = d;
            sb.push_back(e);
        end
        valid_i = 1'b0;
        grant_i = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        valid_i = 1'b0;
        grant_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_cnt = 3'd0;
        m_rec = D_NULL;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 2 * DEPTH && sb.size() > 0; i++) begin
            cyc(tag, 1'b0, '0, '0, 1'b1);
        end
        chk({tag, ".drained_ready"}, 64'(ready_o), 64'(1));
    endtask

    initial begin
        rst     = 1'b0;
        valid_i = 1'b0;
        grant_i = 1'b0;
        flit_i  = '0;
        dir_i   = '0;
        m_cnt   = 3'd0;
        m_rec   = D_NULL;

        // Reset and idle, then grants on an empty buffer.
        do_reset();
        chk("rst.ready", 64'(ready_o),      64'(1));
        chk("rst.dir",   64'(dir_o),        64'(D_NULL));
        chk("rst.count", 64'(count_o),      64'(0));
        chk("rst.rec",   64'(dir_record_o), 64'(D_NULL));
        chk("rst.tail",  64'(tail_o),       64'(0));
        chk("rst.flit",  64'(flit_o),       64'(0));
        for (int i = 0; i < 3; i++) cyc("empty_grant", 1'b0, '0, '0, 1'b1);
        chk("empty_grant.count", 64'(count_o),      64'(0));
        chk("empty_grant.rec",   64'(dir_record_o), 64'(D_NULL));

        // One packet, header east, with a grant every cycle.
        cyc("pkt1", 1'b1, 32'hA0, D_E, 1'b1);
        cyc("pkt1", 1'b1, 32'hA1, 6'd0, 1'b1);
        chk("pkt1.rec_after_hdr", 64'(dir_record_o), 64'(D_E));
        cyc("pkt1", 1'b1, 32'hA2, 6'd0, 1'b1);
        cyc("pkt1", 1'b1, 32'hA3, 6'd0, 1'b1);
        chk("pkt1.tail_at_flit4", 64'(tail_o), 64'(1));
        chk("pkt1.flit4", 64'(flit_o), 64'(32'hA3));
        drain("pkt1");
        chk("pkt1.count_end", 64'(count_o),      64'(0));
        chk("pkt1.rec_end",   64'(dir_record_o), 64'(D_E));

        // Fill without grants, then push and grant while full.
        cyc("fill", 1'b1, 32'hB0, D_S, 1'b0);
        cyc("fill", 1'b1, 32'hB1, 6'd0, 1'b0);
        cyc("fill", 1'b1, 32'hB2, 6'd0, 1'b0);
        cyc("fill", 1'b1, 32'hB3, 6'd0, 1'b0);
        chk("fill.ready_full", 64'(ready_o), 64'(0));
        cyc("full_pushpop", 1'b1, 32'hBF, 6'd0, 1'b1);
        chk("full_pushpop.ready", 64'(ready_o), 64'(1));
        chk("full_pushpop.head",  64'(flit_o),  64'(32'hB1));
        chk("full_pushpop.occ",   64'(sb.size()), 64'(3));
        drain("fill");

        // Two back-to-back packets: north then local.
        cyc("b2b", 1'b1, 32'hC0, D_N, 1'b1);
        for (int i = 1; i < PLEN; i++) cyc("b2b", 1'b1, 32'hC0 + 32'(i), 6'd0, 1'b1);
        chk("b2b.rec_n", 64'(dir_record_o), 64'(D_N));
        chk("b2b.tail_before_wrap", 64'(tail_o), 64'(1));
        cyc("b2b", 1'b1, 32'hD0, D_L, 1'b1);
        chk("b2b.count_wrapped", 64'(count_o),      64'(0));
        chk("b2b.rec_still_n",   64'(dir_record_o), 64'(D_N));
        for (int i = 1; i < PLEN; i++) cyc("b2b", 1'b1, 32'hD0 + 32'(i), 6'd0, 1'b1);
        chk("b2b.rec_l", 64'(dir_record_o), 64'(D_L));
        drain("b2b");

        // Reset part-way through a packet.
        for (int i = 0; i < PLEN; i++) cyc("midrst", 1'b1, 32'hE0 + 32'(i), (i == 0) ? D_WST : 6'd0, 1'b0);
        cyc("midrst", 1'b0, '0, '0, 1'b1);
        cyc("midrst", 1'b0, '0, '0, 1'b1);
        chk("midrst.count_before", 64'(count_o), 64'(2));
        do_reset();
        chk("midrst.count", 64'(count_o),      64'(0));
        chk("midrst.ready", 64'(ready_o),      64'(1));
        chk("midrst.dir",   64'(dir_o),        64'(D_NULL));
        chk("midrst.rec",   64'(dir_record_o), 64'(D_NULL));
        cyc("fresh", 1'b1, 32'hF0, D_E, 1'b0);
        chk("fresh.count", 64'(count_o), 64'(0));
        chk("fresh.head",  64'(flit_o),  64'(32'hF0));
        for (int i = 1; i < PLEN; i++) cyc("fresh", 1'b1, 32'hF0 + 32'(i), 6'd0, 1'b1);
        drain("fresh");
        chk("fresh.rec", 64'(dir_record_o), 64'(D_E));

        // Pointer wrap: stream ten flits at one push and one grant per cycle.
        for (int i = 1; i <= 10; i++) begin
            cyc("wrap", 1'b1, 32'(i), ((i - 1) % PLEN == 0) ? D_S : 6'd0, 1'b1);
            chk("wrap.ready", 64'(ready_o), 64'(1));
            chk("wrap.head",  64'(flit_o),  64'(i));
        end
        drain("wrap");
        check_state("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
